operand_execute_stage: RTL and testbench
========================================

// Module: operand_execute_stage
// PURPOSE
//  Operand-fetch/execute/write-back back end of the pipelined processor; consumes decoder controls (RW MD BS PS MW FS MB MA CS, DA/AA/BA).
//  Holds 32x32 register file, DOF->EX and EX->WB pipeline registers, function unit, data-memory port, Z/BrA/RAA for the PC select mux.
// PARAMETERS
//  DW       32  datapath width
//  NREG     32  register count; R0 reads 0, writes ignored
//  IMMW     15  immediate width (instruction[14:0])
// PORTS
//  clk        in   1   rising-edge clock
//  reset_n    in   1   asynchronous active-low reset
//  AA,BA,DA   in   5   source A, source B, destination register addresses
//  RW,MW      in   1   register write / memory write enables
//  MD,BS      in   2   result select / branch select
//  PS,MB,MA,CS in  1   branch polarity, B=imm, A=PC, imm sign-extend
//  FS         in   4   function select
//  imm        in   15  immediate field
//  pc_dof     in   32  PC of instruction in decode
//  mem_rdata  in   32  data memory read data (async read)
//  mem_addr   out  32  = EX A operand
//  mem_wdata  out  32  = EX B operand
//  mem_we     out  1   = EX MW
//  ex_BS      out  2   EX-stage branch select
//  ex_PS      out  1   EX-stage polarity
//  Z          out  1   EX function result == 0
//  BrA        out  32  ex_pc + sext(imm)
//  RAA        out  32  EX A operand (JMR target)
//  stall      out  1   hold PC/IR; EX receives bubble
// BEHAVIOUR
//  - Reset: regfile, EX/WB regs all 0 (bubble: RW=MW=0, BS=00). Outputs: mem_we=0, ex_BS=0, BrA=0, RAA=0, stall=0, Z=1.
//  - DOF (comb): A=MA?pc_dof:R[AA]; B=MB?(CS?sext(imm):zext(imm)):R[BA]. Same-cycle WB write visible (write-through).
//  - EX regs load every posedge; stall=1 loads bubble, keeps controls zeroed.
//  - FS: 0000 A; 0001 A+1; 0010 A+B; 0011 A+B+1; 0100 A+~B; 0101 A+~B+1; 0110 A-1; 0111 A;
//        1000 A&B; 1001 A|B; 1010 A^B; 1011 ~A; 1100 B; 1101 A>>imm[4:0]; 1110 A<<imm[4:0]; 1111 0.
//  - Arithmetic mod 2^32; carry discarded. V/N computed internally for SLT.
//  - MD: 00 F; 01 mem_rdata; 10 {31'b0, N^V}; 11 F.
//  - WB reg latches result/DA/RW at posedge; regfile written next posedge; DA=0 never written.
//  - Latency: op in DOF at cycle n -> EX at n+1 -> regfile written end of n+2.
//  - Branches: Z, BrA, RAA, ex_BS, ex_PS reflect EX; no flush (one delay slot, owned by PC logic).
//  - Reset mid-operation: all in-flight EX/WB work discarded; no partial regfile write.
//  - Simultaneous WB write and DOF read of same reg: new value read.
// CONFIGURATION
//  FORWARDING_EN defined: EX result (incl. mem_rdata for LD) bypassed to DOF A/B when addr==ex_DA, ex_RW=1, ex_DA!=0; stall tied 0.
//  FORWARDING_EN undefined: no bypass; stall=1 when ex_RW & ex_DA!=0 & ((!MA & AA==ex_DA) | (!MB & BA==ex_DA)); one bubble inserted, stall drops next cycle.
// TESTING
//  R1=5,R2=7; ADD R3,R1,R2 then ADD R4,R3,R1 -> R4=17; stall 1 cycle iff FORWARDING_EN undefined.
//  ADI R5,R0,imm=0x7FFF CS=1 -> R5=0xFFFFFFFF; AIU same imm CS=0 -> 0x00007FFF.
//  ST R1->[R2]: mem_we=1, mem_addr=7, mem_wdata=5 one cycle; LD R6,[R2] with mem_rdata=0xA5 -> R6=0xA5.
//  SLT R1=-1,R2=2 -> 1; BZ with R1=0, imm=4, pc=10 -> Z=1, ex_BS=01, BrA=14.
//  MOVA R0,R1 -> R0 still reads 0; LSL R1 by imm=4 -> 0x50.
//  Assert reset_n low with ADD in EX -> no regfile write, Z=1, outputs 0; resumes cleanly after release.

Source files
------------

// File: rtl/operand_execute_stage.sv
// Operand fetch, execute and write-back: 32x32 regfile, DOF->EX and EX->WB registers, function unit, memory port, branch outputs.
// Result reaches the regfile two edges after DOF; without FORWARDING_EN a RAW hit on EX raises stall for one bubble.
module operand_execute_stage #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int IMMW = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [$clog2(NREG)-1:0]  AA,
  input  logic [$clog2(NREG)-1:0]  BA,
  input  logic [$clog2(NREG)-1:0]  DA,
  input  logic                     RW,
  input  logic                     MW,
  input  logic [1:0]               MD,
  input  logic [1:0]               BS,
  input  logic                     PS,
  input  logic                     MB,
  input  logic                     MA,
  input  logic                     CS,
  input  logic [3:0]               FS,
  input  logic [IMMW-1:0]          imm,
  input  logic [DW-1:0]            pc_dof,
  input  logic [DW-1:0]            mem_rdata,
  output logic [DW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  output logic                     mem_we,
  output logic [1:0]               ex_BS,
  output logic                     ex_PS,
  output logic                     Z,
  output logic [DW-1:0]            BrA,
  output logic [DW-1:0]            RAA,
  output logic                     stall
);

  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(DW);

  typedef struct packed {
    logic            rw;
    logic            mw;
    logic [1:0]      md;
    logic [1:0]      bs;
    logic            ps;
    logic [3:0]      fs;
    logic [AW-1:0]   da;
    logic [IMMW-1:0] imm;
    logic [DW-1:0]   pc;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
  } ex_t;

  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];
  ex_t           ex_q, ex_d;
  logic          wb_rw_q, wb_rw_d;
  logic [AW-1:0] wb_da_q, wb_da_d;
  logic [DW-1:0] wb_res_q, wb_res_d;

  logic [DW-1:0] rd_a, rd_b, op_a, op_b, imm_ext;
  logic [DW-1:0] alu_f, ex_res, add_b, add_sum;
  logic          add_cin, add_cout, add_v, add_n;

  // Priority: EX bypass (when built in), then WB write-through, then array.
  function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] addr);
    logic [DW-1:0] v;
    if (addr == '0)
      v = '0;
    else if (wb_rw_q && wb_da_q == addr)
      v = wb_res_q;
    else
      v = rf_q[addr];
`ifdef FORWARDING_EN
    if (addr != '0 && ex_q.rw && ex_q.da == addr)
      v = ex_res;
`endif
    return v;
  endfunction

  always_comb begin
    rd_a    = rd_port(AA);
    rd_b    = rd_port(BA);
    imm_ext = CS ? {{(DW-IMMW){imm[IMMW-1]}}, imm} : {{(DW-IMMW){1'b0}}, imm};
    op_a    = MA ? pc_dof : rd_a;
    op_b    = MB ? imm_ext : rd_b;
  end

`ifdef FORWARDING_EN
  assign stall = 1'b0;
`else
  assign stall = ex_q.rw && (ex_q.da != '0) &&
                 ((!MA && AA == ex_q.da) || (!MB && BA == ex_q.da));
`endif

  always_comb begin
    ex_d = '0;
    if (!stall) begin
      ex_d.rw  = RW;
      ex_d.mw  = MW;
      ex_d.md  = MD;
      ex_d.bs  = BS;
      ex_d.ps  = PS;
      ex_d.fs  = FS;
      ex_d.da  = DA;
      ex_d.imm = imm;
      ex_d.pc  = pc_dof;
      ex_d.a   = op_a;
      ex_d.b   = op_b;
    end
  end

  // One adder serves every arithmetic code; its flags feed set-less-than.
  always_comb begin
    add_b   = '0;
    add_cin = 1'b0;
    case (ex_q.fs)
      4'b0001: add_cin = 1'b1;
      4'b0010: add_b   = ex_q.b;
      4'b0011: begin add_b = ex_q.b;  add_cin = 1'b1; end
      4'b0100: add_b   = ~ex_q.b;
      4'b0101: begin add_b = ~ex_q.b; add_cin = 1'b1; end
      4'b0110: add_b   = '1;
      default: ;
    endcase
    {add_cout, add_sum} = {1'b0, ex_q.a} + {1'b0, add_b} + {{DW{1'b0}}, add_cin};
    add_v = add_cout ^ (ex_q.a[DW-1] ^ add_b[DW-1] ^ add_sum[DW-1]);
    add_n = add_sum[DW-1];
  end

  always_comb begin
    alu_f = '0;
    case (ex_q.fs)
      4'b0000, 4'b0111: alu_f = ex_q.a;
      4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110: alu_f = add_sum;
      4'b1000: alu_f = ex_q.a & ex_q.b;
      4'b1001: alu_f = ex_q.a | ex_q.b;
      4'b1010: alu_f = ex_q.a ^ ex_q.b;
      4'b1011: alu_f = ~ex_q.a;
      4'b1100: alu_f = ex_q.b;
      4'b1101: alu_f = ex_q.a >> ex_q.imm[SW-1:0];
      4'b1110: alu_f = ex_q.a << ex_q.imm[SW-1:0];
      default: alu_f = '0;
    endcase
  end

  always_comb begin
    case (ex_q.md)
      2'b01:   ex_res = mem_rdata;
      2'b10:   ex_res = {{(DW-1){1'b0}}, add_n ^ add_v};
      default: ex_res = alu_f;
    endcase
  end

  always_comb begin
    wb_rw_d  = ex_q.rw;
    wb_da_d  = ex_q.da;
    wb_res_d = ex_res;
    rf_d     = rf_q;
    if (wb_rw_q && wb_da_q != '0)
      rf_d[wb_da_q] = wb_res_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      ex_q     <= '0;
      wb_rw_q  <= 1'b0;
      wb_da_q  <= '0;
      wb_res_q <= '0;
    end else begin
      rf_q     <= rf_d;
      ex_q     <= ex_d;
      wb_rw_q  <= wb_rw_d;
      wb_da_q  <= wb_da_d;
      wb_res_q <= wb_res_d;
    end
  end

  assign mem_addr  = ex_q.a;
  assign mem_wdata = ex_q.b;
  assign mem_we    = ex_q.mw;
  assign ex_BS     = ex_q.bs;
  assign ex_PS     = ex_q.ps;
  assign Z         = (alu_f == '0);
  assign BrA       = ex_q.pc + {{(DW-IMMW){ex_q.imm[IMMW-1]}}, ex_q.imm};
  assign RAA       = ex_q.a;

endmodule

// File: tb/tb_operand_execute_stage.sv
// Directed bench for operand_execute_stage; register contents are read back by issuing a MOVA and observing RAA.
module tb_operand_execute_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  AA, BA, DA;
  logic        RW, MW, PS, MB, MA, CS;
  logic [1:0]  MD, BS;
  logic [3:0]  FS;
  logic [14:0] imm;
  logic [31:0] pc_dof, mem_rdata;
  logic [31:0] mem_addr, mem_wdata, BrA, RAA;
  logic        mem_we, ex_PS, Z, stall;
  logic [1:0]  ex_BS;

  int vectors = 0;
  int errors  = 0;
  int stall_cnt;

`ifdef FORWARDING_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 1;
`endif

  always #5 clk = ~clk;

  operand_execute_stage dut (
    .clk(clk), .reset_n(reset_n),
    .AA(AA), .BA(BA), .DA(DA),
    .RW(RW), .MW(MW), .MD(MD), .BS(BS),
    .PS(PS), .MB(MB), .MA(MA), .CS(CS),
    .FS(FS), .imm(imm), .pc_dof(pc_dof), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .ex_BS(ex_BS), .ex_PS(ex_PS), .Z(Z), .BrA(BrA), .RAA(RAA), .stall(stall)
  );

  // Presents one instruction in DOF, holds it through any stall, returns #1 after it enters EX.
  task automatic issue(input logic [4:0] da, aa, ba,
                       input logic rw, mw, ps, mb, ma, cs,
                       input logic [1:0] md, bs, input logic [3:0] fs,
                       input logic [14:0] im, input logic [31:0] pc);
    DA = da; AA = aa; BA = ba; RW = rw; MW = mw; PS = ps; MB = mb; MA = ma; CS = cs;
    MD = md; BS = bs; FS = fs; imm = im; pc_dof = pc;
    #1;
    stall_cnt = 0;
    while (stall === 1'b1 && stall_cnt < 4) begin
      @(posedge clk); #1;
      stall_cnt++;
    end
    if (stall_cnt >= 4) begin
      vectors++; errors++;
      $display("FAIL stall_timeout: stall still %b after %0d cycles, required 0", stall, stall_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic nop();
    issue(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 15'h0, 32'h0);
  endtask

  task automatic alu(input logic [4:0] da, aa, ba, input logic [3:0] fs,
                     input logic [14:0] im, input logic [1:0] md);
    issue(da, aa, ba, 1, 0, 0, 0, 0, 0, md, 2'b00, fs, im, 32'h0);
  endtask

  task automatic addi(input logic [4:0] da, aa, input logic [14:0] im, input logic cs);
    issue(da, aa, 5'd0, 1, 0, 0, 1, 0, cs, 2'b00, 2'b00, 4'h2, im, 32'h0);
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    issue(5'd0, r, 5'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 15'h0, 32'h0);
    v = RAA;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mem_rdata = 32'h0;
    DA = 0; AA = 0; BA = 0; RW = 0; MW = 0; PS = 0; MB = 0; MA = 0; CS = 0;
    MD = 0; BS = 0; FS = 0; imm = 0; pc_dof = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (Z !== 1'b1) begin errors++; $display("FAIL reset_Z: got %b want 1", Z); end
    vectors++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    vectors++; if (ex_BS !== 2'b00) begin errors++; $display("FAIL reset_ex_BS: got %b want 00", ex_BS); end
    vectors++; if (BrA !== 32'h0) begin errors++; $display("FAIL reset_BrA: got %h want 0", BrA); end
    vectors++; if (RAA !== 32'h0) begin errors++; $display("FAIL reset_RAA: got %h want 0", RAA); end
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_setup();
    logic [31:0] v;
    addi(5'd1, 5'd0, 15'd5, 1'b1);
    addi(5'd2, 5'd0, 15'd7, 1'b1);
    read_reg(5'd1, v);
    vectors++; if (v !== 32'd5) begin errors++; $display("FAIL setup_R1: got %h want 5", v); end
    read_reg(5'd2, v);
    vectors++; if (v !== 32'd7) begin errors++; $display("FAIL setup_R2: got %h want 7", v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    alu(5'd3, 5'd1, 5'd2, 4'h2, 15'd0, 2'b00);
    alu(5'd4, 5'd3, 5'd1, 4'h2, 15'd0, 2'b00);
    vectors++;
    if (stall_cnt !== EXP_STALL) begin errors++; $display("FAIL raw_stall_cycles: got %0d want %0d", stall_cnt, EXP_STALL); end
    read_reg(5'd4, v);
    vectors++; if (v !== 32'd17) begin errors++; $display("FAIL raw_R4: got %h want 17", v); end
    read_reg(5'd3, v);
    vectors++; if (v !== 32'd12) begin errors++; $display("FAIL raw_R3: got %h want 12", v); end
  endtask

  task automatic test_imm();
    logic [31:0] v;
    addi(5'd5, 5'd0, 15'h7FFF, 1'b1);
    read_reg(5'd5, v);
    vectors++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL adi_sext: got %h want ffffffff", v); end
    addi(5'd7, 5'd0, 15'h7FFF, 1'b0);
    read_reg(5'd7, v);
    vectors++; if (v !== 32'h0000_7FFF) begin errors++; $display("FAIL aiu_zext: got %h want 00007fff", v); end
  endtask

  // A=R1=5, B=R2=7, shift amount imm=1
  task automatic test_alu_table();
    logic [31:0] exp_tab [16] = '{32'd5, 32'd6, 32'd12, 32'd13, 32'hFFFF_FFFD, 32'hFFFF_FFFE,
                                  32'd4, 32'd5, 32'd5, 32'd7, 32'd2, 32'hFFFF_FFFA,
                                  32'd7, 32'd2, 32'd10, 32'd0};
    logic [31:0] v;
    for (int f = 0; f < 16; f++) begin
      alu(5'd13, 5'd1, 5'd2, 4'(f), 15'd1, 2'b00);
      read_reg(5'd13, v);
      vectors++;
      if (v !== exp_tab[f]) begin errors++; $display("FAIL alu_fs%0d: got %h want %h", f, v, exp_tab[f]); end
    end
  endtask

  task automatic test_mem();
    logic [31:0] v;
    issue(5'd0, 5'd2, 5'd1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 15'h0, 32'h0);
    vectors++; if (mem_we !== 1'b1) begin errors++; $display("FAIL st_we: got %b want 1", mem_we); end
    vectors++; if (mem_addr !== 32'd7) begin errors++; $display("FAIL st_addr: got %h want 7", mem_addr); end
    vectors++; if (mem_wdata !== 32'd5) begin errors++; $display("FAIL st_wdata: got %h want 5", mem_wdata); end
    nop();
    vectors++; if (mem_we !== 1'b0) begin errors++; $display("FAIL st_we_one_cycle: got %b want 0", mem_we); end
    mem_rdata = 32'h0000_00A5;
    issue(5'd6, 5'd2, 5'd0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 4'h0, 15'h0, 32'h0);
    vectors++; if (mem_addr !== 32'd7) begin errors++; $display("FAIL ld_addr: got %h want 7", mem_addr); end
    read_reg(5'd6, v);
    mem_rdata = 32'h0;
    vectors++; if (v !== 32'hA5) begin errors++; $display("FAIL ld_R6: got %h want a5", v); end
  endtask

  task automatic test_slt();
    logic [31:0] v;
    addi(5'd8, 5'd0, 15'h7FFF, 1'b1);
    addi(5'd9, 5'd0, 15'd2, 1'b1);
    alu(5'd10, 5'd8, 5'd9, 4'h5, 15'd0, 2'b10);
    read_reg(5'd10, v);
    vectors++; if (v !== 32'd1) begin errors++; $display("FAIL slt_neg_lt: got %h want 1", v); end
    alu(5'd10, 5'd9, 5'd8, 4'h5, 15'd0, 2'b10);
    read_reg(5'd10, v);
    vectors++; if (v !== 32'd0) begin errors++; $display("FAIL slt_ge: got %h want 0", v); end
  endtask

  task automatic test_branch();
    issue(5'd0, 5'd11, 5'd0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 4'h0, 15'd4, 32'd10);
    vectors++; if (Z !== 1'b1) begin errors++; $display("FAIL bz_Z: got %b want 1", Z); end
    vectors++; if (ex_BS !== 2'b01) begin errors++; $display("FAIL bz_ex_BS: got %b want 01", ex_BS); end
    vectors++; if (BrA !== 32'd14) begin errors++; $display("FAIL bz_BrA: got %h want e", BrA); end
    vectors++; if (ex_PS !== 1'b1) begin errors++; $display("FAIL bz_ex_PS: got %b want 1", ex_PS); end
    issue(5'd0, 5'd1, 5'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 4'h0, 15'h7FFC, 32'd100);
    vectors++; if (Z !== 1'b0) begin errors++; $display("FAIL bnz_Z: got %b want 0", Z); end
    vectors++; if (BrA !== 32'd96) begin errors++; $display("FAIL back_BrA: got %h want 60", BrA); end
    vectors++; if (RAA !== 32'd5) begin errors++; $display("FAIL jmr_RAA: got %h want 5", RAA); end
  endtask

  task automatic test_r0_and_shift();
    logic [31:0] v;
    alu(5'd0, 5'd1, 5'd0, 4'h0, 15'd0, 2'b00);
    read_reg(5'd0, v);
    vectors++; if (v !== 32'd0) begin errors++; $display("FAIL r0_during_wb: got %h want 0", v); end
    nop();
    nop();
    read_reg(5'd0, v);
    vectors++; if (v !== 32'd0) begin errors++; $display("FAIL r0_after: got %h want 0", v); end
    alu(5'd12, 5'd1, 5'd0, 4'hE, 15'd4, 2'b00);
    read_reg(5'd12, v);
    vectors++; if (v !== 32'h50) begin errors++; $display("FAIL lsl4: got %h want 50", v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    alu(5'd14, 5'd1, 5'd2, 4'h2, 15'd0, 2'b00);
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (Z !== 1'b1) begin errors++; $display("FAIL rst_mid_Z: got %b want 1", Z); end
    vectors++; if (RAA !== 32'h0) begin errors++; $display("FAIL rst_mid_RAA: got %h want 0", RAA); end
    vectors++; if (BrA !== 32'h0) begin errors++; $display("FAIL rst_mid_BrA: got %h want 0", BrA); end
    vectors++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we: got %b want 0", mem_we); end
    nop();
    reset_n = 1'b1;
    nop();
    read_reg(5'd14, v);
    vectors++; if (v !== 32'd0) begin errors++; $display("FAIL rst_mid_R14: got %h want 0", v); end
    addi(5'd1, 5'd0, 15'd3, 1'b1);
    read_reg(5'd1, v);
    vectors++; if (v !== 32'd3) begin errors++; $display("FAIL rst_resume_R1: got %h want 3", v); end
  endtask

  initial begin
    test_reset();
    test_setup();
    test_back_to_back();
    test_imm();
    test_alu_table();
    test_mem();
    test_slt();
    test_branch();
    test_r0_and_shift();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
